hazard_control: RTL and testbench
=================================

HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 Parameter MD_LATENCY, default 32, SHALL set the mult/div busy duration in cycles; legal range is 2 to 63.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 IF_ID_RS  input  5  SHALL be the rs field of the instruction in decode.
REQ-005 IF_ID_RT  input  5  SHALL be the rt field of the instruction in decode.
REQ-006 IF_ID_USES_RT  input  1  SHALL be high when the decode instruction reads rt as a source.
REQ-007 IF_ID_MD_USE  input  1  SHALL be high when the decode instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 ID_EX_RT  input  5  SHALL be the destination rt of the instruction in execute.
REQ-009 ID_EX_MEMREAD  input  1  SHALL be high when the execute instruction is a load.
REQ-010 EX_BRANCH_TAKEN  input  1  SHALL be high when a branch or jump in execute redirects the PC.
REQ-011 MD_START  input  1  SHALL pulse for one cycle when a mult/div enters execute.
REQ-012 PC_WRITE, IF_ID_WRITE  output  1 each  SHALL enable PC and IF/ID register updates.
REQ-013 ID_EX_BUBBLE  output  1  SHALL zero the control fields entering ID/EX.
REQ-014 IF_ID_FLUSH  output  1  SHALL clear IF/ID to a nop.
REQ-015 MD_BUSY  output  1  SHALL be high while the mult/div unit is computing.
REQ-016 STALL_CNT  output  16  SHALL count stall cycles.

Function
REQ-017 Load-use hazard SHALL be detected when ID_EX_MEMREAD=1, ID_EX_RT!=0, and ID_EX_RT==IF_ID_RS, or IF_ID_USES_RT=1 with ID_EX_RT==IF_ID_RT.
REQ-018 A load-use hazard SHALL drive PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1 combinationally in the same cycle.
REQ-019 The FSM SHALL have exactly two states, IDLE and MD_WAIT.
REQ-020 In IDLE, MD_START=1 SHALL load the down-counter with MD_LATENCY-1 and move to MD_WAIT.
REQ-021 In MD_WAIT the counter SHALL decrement once per cycle, and the FSM SHALL return to IDLE on the cycle after the counter reads 0.
REQ-022 MD_START received while in MD_WAIT SHALL be ignored.
REQ-023 MD_BUSY SHALL be 1 exactly while in MD_WAIT, giving MD_LATENCY cycles of busy per start.
REQ-024 In MD_WAIT with IF_ID_MD_USE=1, the block SHALL stall with the same outputs as REQ-018.
REQ-025 EX_BRANCH_TAKEN=1 SHALL force IF_ID_FLUSH=1, ID_EX_BUBBLE=1 and PC_WRITE=1.
REQ-026 Branch flush SHALL override any load-use or mult/div stall in the same cycle.
REQ-027 STALL_CNT SHALL increment on every cycle with PC_WRITE=0 and saturate at 16'hFFFF.
REQ-028 With no hazard, the outputs SHALL be PC_WRITE=1, IF_ID_WRITE=1, ID_EX_BUBBLE=0, IF_ID_FLUSH=0.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, counter=0 and STALL_CNT=0, independent of clk.
REQ-030 Asserting reset during MD_WAIT SHALL abort the operation, with MD_BUSY=0 on assertion.
REQ-031 While in reset, the combinational outputs SHALL follow REQ-028 unless a load-use hazard or branch input is present.

Configuration
REQ-032 Macro HAZARD_MULDIV_EN defined SHALL include the FSM, counter, MD_BUSY and the REQ-024 stall.
REQ-033 Macro HAZARD_MULDIV_EN undefined SHALL remove that logic, tie MD_BUSY to 0, ignore MD_START and IF_ID_MD_USE, and keep all ports.

Structure
REQ-034 A shared package SHALL hold the FSM state typedef, the REG_ZERO constant (5'd0) and the register-index width constant (5).
REQ-035 The busy counter SHALL be a sub-module, md_busy_timer, with inputs start and clear and outputs busy and count.

Verification
REQ-036 Load to $8 in EX with IF_ID_RS=8 -> one cycle of PC_WRITE=0 and ID_EX_BUBBLE=1; STALL_CNT 0->1.
REQ-037 ID_EX_MEMREAD=1, ID_EX_RT=0, IF_ID_RS=0 -> no stall; outputs per REQ-028.
REQ-038 MD_LATENCY=4, MD_START pulse, then IF_ID_MD_USE=1 -> MD_BUSY high 4 cycles, stalled 4 cycles, released on cycle 5.
REQ-039 Load-use hazard plus EX_BRANCH_TAKEN=1 in the same cycle -> IF_ID_FLUSH=1, PC_WRITE=1, ID_EX_BUBBLE=1.
REQ-040 rst_n low in the 2nd MD_WAIT cycle -> MD_BUSY=0 immediately; STALL_CNT=0; IDLE after release.
REQ-041 STALL_CNT preloaded to 16'hFFFE, then 3 stall cycles -> STALL_CNT holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_control_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_control_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  // Wide enough for the largest legal mult/div latency (63).
  localparam int MD_CNT_W = 6;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_WAIT = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div busy down-counter: start loads LATENCY-1, then counts down to zero.
module md_busy_timer
  import hazard_control_pkg::*;
#(
  parameter int LATENCY = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                clear,
  output logic                busy,
  output logic [MD_CNT_W-1:0] count
);

  logic [MD_CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (start) begin
      count_reg <= MD_CNT_W'(LATENCY - 1);
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign busy  = (count_reg != '0);
  assign count = count_reg;

endmodule

// File: rtl/hazard_control.sv
// Load-use / mult-div stall and branch-flush control for a 5-stage pipeline.
// Mult/div busy tracking is compiled in only when HAZARD_MULDIV_EN is defined.
module hazard_control
  import hazard_control_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] IF_ID_RS,
  input  logic [REG_IDX_W-1:0] IF_ID_RT,
  input  logic                 IF_ID_USES_RT,
  input  logic                 IF_ID_MD_USE,
  input  logic [REG_IDX_W-1:0] ID_EX_RT,
  input  logic                 ID_EX_MEMREAD,
  input  logic                 EX_BRANCH_TAKEN,
  input  logic                 MD_START,
  output logic                 PC_WRITE,
  output logic                 IF_ID_WRITE,
  output logic                 ID_EX_BUBBLE,
  output logic                 IF_ID_FLUSH,
  output logic                 MD_BUSY,
  output logic [15:0]          STALL_CNT
);

  logic        load_use;
  logic        md_stall;
  logic        stall;
  logic [15:0] stall_cnt_reg;

  // $zero is never a real load destination, so it cannot create a hazard.
  assign load_use = ID_EX_MEMREAD && (ID_EX_RT != REG_ZERO) &&
                    ((ID_EX_RT == IF_ID_RS) ||
                     (IF_ID_USES_RT && (ID_EX_RT == IF_ID_RT)));

`ifdef HAZARD_MULDIV_EN
  md_state_t           state_reg;
  md_state_t           state_next;
  logic                timer_start;
  logic                timer_clear;
  logic                timer_busy;
  logic [MD_CNT_W-1:0] timer_count_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A start seen while already waiting is dropped: only IDLE reacts to MD_START.
  always_comb begin
    state_next  = state_reg;
    timer_start = 1'b0;
    timer_clear = 1'b0;
    case (state_reg)
      IDLE: begin
        if (MD_START) begin
          timer_start = 1'b1;
          state_next  = MD_WAIT;
        end else begin
          timer_clear = 1'b1;
        end
      end
      MD_WAIT: begin
        if (!timer_busy) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  md_busy_timer #(
    .LATENCY(MD_LATENCY)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .start(timer_start),
    .clear(timer_clear),
    .busy (timer_busy),
    .count(timer_count_unused)
  );

  assign MD_BUSY  = (state_reg == MD_WAIT);
  assign md_stall = MD_BUSY && IF_ID_MD_USE;
`else
  logic unused_md;

  assign unused_md = ^{MD_START, IF_ID_MD_USE, MD_LATENCY[0]};
  assign MD_BUSY   = 1'b0;
  assign md_stall  = 1'b0;
`endif

  assign stall = load_use || md_stall;

  // A taken branch squashes the stalled instruction anyway, so it wins.
  always_comb begin
    PC_WRITE     = 1'b1;
    IF_ID_WRITE  = 1'b1;
    ID_EX_BUBBLE = 1'b0;
    IF_ID_FLUSH  = 1'b0;
    if (EX_BRANCH_TAKEN) begin
      IF_ID_FLUSH  = 1'b1;
      ID_EX_BUBBLE = 1'b1;
    end else if (stall) begin
      PC_WRITE     = 1'b0;
      IF_ID_WRITE  = 1'b0;
      ID_EX_BUBBLE = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (!PC_WRITE && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign STALL_CNT = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: vector table, directed corner cases and
// randomized traffic against a behavioural model; honours HAZARD_MULDIV_EN.
`timescale 1ns/1ps
module tb_hazard_control;

  localparam int LAT = 4;
`ifdef HAZARD_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  if_id_rs, if_id_rt, id_ex_rt;
  logic        if_id_uses_rt, if_id_md_use, id_ex_memread, ex_branch_taken, md_start;
  logic        pc_write, if_id_write, id_ex_bubble, if_id_flush, md_busy;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  // Model: cycles of busy still owed by the mult/div unit, and the stall total.
  int m_rem = 0;
  int m_stall = 0;

  always #5 clk = ~clk;

  hazard_control #(.MD_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_RS(if_id_rs), .IF_ID_RT(if_id_rt), .IF_ID_USES_RT(if_id_uses_rt),
    .IF_ID_MD_USE(if_id_md_use), .ID_EX_RT(id_ex_rt), .ID_EX_MEMREAD(id_ex_memread),
    .EX_BRANCH_TAKEN(ex_branch_taken), .MD_START(md_start),
    .PC_WRITE(pc_write), .IF_ID_WRITE(if_id_write), .ID_EX_BUBBLE(id_ex_bubble),
    .IF_ID_FLUSH(if_id_flush), .MD_BUSY(md_busy), .STALL_CNT(stall_cnt)
  );

  typedef struct {
    string      name;
    logic [4:0] rs, rt, ex_rt;
    logic       uses_rt, memread, br;
    logic       pcw, ifw, bub, fl;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    if_id_rs = 0; if_id_rt = 0; id_ex_rt = 0;
    if_id_uses_rt = 0; if_id_md_use = 0; id_ex_memread = 0;
    ex_branch_taken = 0; md_start = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0; m_rem = 0; m_stall = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
  endtask

  // One clock: compare against the model at the falling edge, then advance the model.
  task automatic cycle(input string tag);
    logic lu, mds, pcw, bub, fl;
    @(negedge clk);
    lu  = id_ex_memread && (id_ex_rt != 0) &&
          ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
    mds = (m_rem > 0) && if_id_md_use;
    fl  = ex_branch_taken;
    bub = ex_branch_taken || lu || mds;
    pcw = ex_branch_taken || !(lu || mds);
    chk({tag, ".pc_write"}, 32'(pc_write), 32'(pcw));
    if (!ex_branch_taken) chk({tag, ".if_id_write"}, 32'(if_id_write), 32'(pcw));
    chk({tag, ".bubble"}, 32'(id_ex_bubble), 32'(bub));
    chk({tag, ".flush"}, 32'(if_id_flush), 32'(fl));
    chk({tag, ".md_busy"}, 32'(md_busy), 32'(m_rem > 0));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    $display("%s rs=%0d rt=%0d use_rt=%0b ex_rt=%0d ld=%0b br=%0b mds=%0b mdu=%0b -> pcw=%0b bub=%0b fl=%0b busy=%0b cnt=%0d",
             tag, if_id_rs, if_id_rt, if_id_uses_rt, id_ex_rt, id_ex_memread, ex_branch_taken,
             md_start, if_id_md_use, pc_write, id_ex_bubble, if_id_flush, md_busy, stall_cnt);
    @(posedge clk);
    if (!pcw && m_stall < 65535) m_stall++;
    if (m_rem > 0) m_rem--;
    else if (MD_EN && md_start) m_rem = LAT;
    #1;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"no_load",      5'd8, 5'd0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"lu_rs",        5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"lu_rt",        5'd3, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{"rt_not_used",  5'd3, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"zero_rs",      5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{"zero_rt",      5'd4, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{"branch",       5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{"lu_and_br",    5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{"no_match",     5'd7, 5'd6, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset: counters cleared, outputs idle, hazards still decoded combinationally.
    clear_inputs();
    rst_n = 0;
    #12;
    chk("rst.pc_write", 32'(pc_write), 32'd1);
    chk("rst.if_id_write", 32'(if_id_write), 32'd1);
    chk("rst.bubble", 32'(id_ex_bubble), 32'd0);
    chk("rst.flush", 32'(if_id_flush), 32'd0);
    chk("rst.md_busy", 32'(md_busy), 32'd0);
    chk("rst.stall_cnt", 32'(stall_cnt), 32'd0);
    id_ex_memread = 1; id_ex_rt = 5; if_id_rs = 5; md_start = 1;
    @(posedge clk); #1;
    chk("rst_lu.pc_write", 32'(pc_write), 32'd0);
    chk("rst_lu.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_lu.md_busy", 32'(md_busy), 32'd0);
    do_reset();

    // Single load-use stall on $8.
    id_ex_memread = 1; id_ex_rt = 8; if_id_rs = 8;
    #2;
    chk("lu8.pc_write", 32'(pc_write), 32'd0);
    chk("lu8.bubble", 32'(id_ex_bubble), 32'd1);
    chk("lu8.cnt_before", 32'(stall_cnt), 32'd0);
    cycle("lu8");
    clear_inputs();
    #2;
    chk("lu8.cnt_after", 32'(stall_cnt), 32'd1);
    chk("lu8.released", 32'(pc_write), 32'd1);
    cycle("lu8_idle");

    // Combinational vector table.
    for (int i = 0; i < 9; i++) begin
      if_id_rs = vecs[i].rs; if_id_rt = vecs[i].rt; id_ex_rt = vecs[i].ex_rt;
      if_id_uses_rt = vecs[i].uses_rt; id_ex_memread = vecs[i].memread;
      ex_branch_taken = vecs[i].br;
      #2;
      chk({"tbl.", vecs[i].name, ".pcw"}, 32'(pc_write), 32'(vecs[i].pcw));
      if (!vecs[i].br) chk({"tbl.", vecs[i].name, ".ifw"}, 32'(if_id_write), 32'(vecs[i].ifw));
      chk({"tbl.", vecs[i].name, ".bub"}, 32'(id_ex_bubble), 32'(vecs[i].bub));
      chk({"tbl.", vecs[i].name, ".fl"}, 32'(if_id_flush), 32'(vecs[i].fl));
      cycle({"tbl.", vecs[i].name});
    end

    // Mult/div: busy for LAT cycles, dependent instruction released on cycle LAT+1.
    do_reset();
    md_start = 1;
    cycle("md_start");
    md_start = 0; if_id_md_use = 1;
    for (int i = 0; i < LAT; i++) begin
      #2;
      chk("md.busy", 32'(md_busy), 32'(MD_EN));
      chk("md.stalled", 32'(pc_write), 32'(!MD_EN));
      md_start = (i == 1);  // ignored while waiting
      cycle("md_wait");
    end
    md_start = 0;
    #2;
    chk("md.busy_done", 32'(md_busy), 32'd0);
    chk("md.released", 32'(pc_write), 32'd1);
    cycle("md_release");
    if_id_md_use = 0;

    // Asynchronous reset in the 2nd wait cycle.
    do_reset();
    id_ex_memread = 1; id_ex_rt = 2; if_id_rs = 2;
    cycle("pre_lu");
    clear_inputs();
    md_start = 1;
    cycle("md_start2");
    md_start = 0; if_id_md_use = 1;
    cycle("md_wait1");
    #1;
    chk("abort.busy_before", 32'(md_busy), 32'(MD_EN));
    #1 rst_n = 0; m_rem = 0; m_stall = 0;
    #1;
    chk("abort.busy", 32'(md_busy), 32'd0);
    chk("abort.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("abort.pc_write", 32'(pc_write), 32'd1);
    rst_n = 1;
    cycle("abort_idle");
    cycle("abort_idle2");
    if_id_md_use = 0;

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if_id_rs = 5'($urandom_range(0, 3));
      if_id_rt = 5'($urandom_range(0, 3));
      id_ex_rt = 5'($urandom_range(0, 3));
      if_id_uses_rt = 1'($urandom_range(0, 1));
      id_ex_memread = 1'($urandom_range(0, 1));
      if_id_md_use = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      md_start = ($urandom_range(0, 7) == 0);
      cycle("rnd");
    end

    // Saturation of the stall counter.
    do_reset();
    id_ex_memread = 1; id_ex_rt = 8; if_id_rs = 8;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat.preload", 32'(stall_cnt), 32'hFFFE);
    m_stall = 65534;
    cycle("sat1");
    cycle("sat2");
    cycle("sat3");
    chk("sat.hold", 32'(stall_cnt), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
